wave_frame_player: RTL and testbench

Downstream stage of the waveform converter. Captures a completed 256-sample, 8-bit frame when the converter signals ready, then plays it out as a continuous sample stream toward the digital filter. Playback uses a phase-accumulator (DDS) index, a programmable sample-rate tick and a valid/ready output handshake. A double buffer lets a new frame be accepted mid-playback without glitches.

---
 rtl/wave_pkg.sv | 21 ++
 rtl/sample_tick_gen.sv | 30 +++
 rtl/wave_frame_player.sv | 180 ++++++++++++++++++
 tb/tb_wave_frame_player.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// wave_pkg: shared frame/sample types for the converter and player.
// Holds frame geometry, the player state encoding and a counter helper.
package wave_pkg;

  localparam int NUM_SAMPLES = 256;
  localparam int SAMPLE_W    = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t [0:NUM_SAMPLES-1] frame_t;

  typedef enum logic [1:0] {
    EMPTY,
    IDLE,
    PLAY
  } player_state_t;

  function automatic sample_t sat_inc(input sample_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: one-cycle tick every CLK_DIV clocks while run=1.
// Ports: clk, rst (async, high), run (count enable, clears when low), tick.
module sample_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW =
    (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = run & (cnt_q == LAST);

endmodule

// File: rtl/wave_frame_player.sv
// wave_frame_player: double-buffered frame capture and DDS sample playback.
// Ports: clk, rst (async, high); frame_rdy, frame_in, reload capture a frame;
// enable, phase_inc drive playback; m_valid/m_ready/m_data stream samples;
// frame_ack pulses per capture; playing flags PLAY; drop_cnt counts drops.
module wave_frame_player
  import wave_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_rdy,
  input  frame_t             frame_in,
  input  logic               reload,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               m_ready,
  output logic               m_valid,
  output sample_t            m_data,
  output logic               frame_ack,
  output logic               playing,
  output logic [7:0]         drop_cnt
);

  player_state_t state_q;
  player_state_t state_d;

  logic               rdy_q;
  logic               cap;
  logic               run;
  logic               tick;
  logic               carry;
  logic               swap;
  logic               load;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_sum;
  logic [7:0]         idx;

  frame_t active_q;
  frame_t shadow_q;
  logic   pend_q;
  logic   pend_d;

  // buffer/phase control decoded by the FSM
  logic wr_act;
  logic cp_sh;
  logic wr_sh;
  logic clr_ph;

  // a rising ready or an explicit reload both capture
  assign cap = frame_rdy & (~rdy_q | reload);

  // PLAY with enable low is the exit cycle: no tick
  assign run = (state_q == PLAY) & enable;

  assign {carry, phase_sum} =
    {1'b0, phase_q} + {1'b0, phase_inc};

  assign idx  = phase_q[PHASE_W-1 -: 8];
  assign swap = tick & carry & pend_q;

  // emit unless the previous sample is still held
  assign load = tick & (~m_valid | m_ready);

  assign playing = (state_q == PLAY);

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wr_act  = 1'b0;
    cp_sh   = 1'b0;
    wr_sh   = 1'b0;
    clr_ph  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (cap) begin
          wr_act  = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        wr_act = cap;
        if (enable) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (!enable) begin
          state_d = IDLE;
          clr_ph  = 1'b1;
          pend_d  = 1'b0;
          // a fresh capture beats the older shadow
          wr_act  = cap;
          cp_sh   = pend_q & ~cap;
        end else begin
          if (swap) begin
            cp_sh  = 1'b1;
            pend_d = 1'b0;
          end
          if (cap) begin
            wr_sh  = 1'b1;
            pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q     <= 1'b0;
      frame_ack <= 1'b0;
      pend_q    <= 1'b0;
      phase_q   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      drop_cnt  <= '0;
    end else begin
      rdy_q     <= frame_rdy;
      frame_ack <= cap;
      pend_q    <= pend_d;

      if (clr_ph) begin
        phase_q <= '0;
      end else if (tick) begin
        phase_q <= phase_sum;
      end

      // read uses the pre-swap active buffer
      if (load) begin
        m_data  <= active_q[idx];
        m_valid <= 1'b1;
      end else if (m_valid & m_ready) begin
        m_valid <= 1'b0;
      end

      if (tick & ~load) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      shadow_q <= '0;
    end else begin
      unique case (1'b1)
        wr_act:  active_q <= frame_in;
        cp_sh:   active_q <= shadow_q;
        default: ;
      endcase
      if (wr_sh) begin
        shadow_q <= frame_in;
      end
    end
  end

endmodule

// File: tb/tb_wave_frame_player.sv
// tb_wave_frame_player: directed plus random stimulus against a
// behavioural model; checks outputs each cycle and key literal values.
module tb_wave_frame_player;
  import wave_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int PHASE_W = 16;
  localparam int PMOD    = 1 << PHASE_W;

  logic               clk       = 1'b0;
  logic               rst       = 1'b1;
  logic               frame_rdy = 1'b0;
  logic               reload    = 1'b0;
  logic               enable    = 1'b0;
  logic               m_ready   = 1'b0;
  frame_t             frame_in  = '0;
  logic [PHASE_W-1:0] phase_inc = '0;
  logic               m_valid;
  sample_t            m_data;
  logic               frame_ack;
  logic               playing;
  logic [7:0]         drop_cnt;

  always #5 clk = ~clk;

  wave_frame_player #(
    .CLK_DIV (CLK_DIV),
    .PHASE_W (PHASE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_rdy (frame_rdy),
    .frame_in  (frame_in),
    .reload    (reload),
    .enable    (enable),
    .phase_inc (phase_inc),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .frame_ack (frame_ack),
    .playing   (playing),
    .drop_cnt  (drop_cnt)
  );

  int      n_cmp   = 0;
  int      n_bad   = 0;
  bit      chk_on  = 0;
  int      ack_cnt = 0;
  sample_t log_q[$];

  function automatic void chk(string nm, logic [31:0] a,
                              logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, a, e, $time);
    end
  endfunction

  // behavioural model: 0=no frame, 1=holding, 2=playing
  int md_st, md_pc, md_ph, md_drop, md_data;
  bit md_rdyq, md_pend, md_valid, md_ack;
  int md_act[256];
  int md_sh[256];

  always @(posedge clk or posedge rst) begin : model
    bit c, r, tk, cy, sw;
    int ix, nx;
    if (rst) begin
      md_st = 0; md_pc = 0; md_ph = 0; md_drop = 0;
      md_data = 0; md_rdyq = 0; md_pend = 0;
      md_valid = 0; md_ack = 0;
      foreach (md_act[i]) begin
        md_act[i] = 0;
        md_sh[i]  = 0;
      end
    end else begin
      c  = frame_rdy && (!md_rdyq || reload);
      r  = (md_st == 2) && enable;
      tk = r && (md_pc % CLK_DIV == CLK_DIV - 1);
      md_pc = r ? md_pc + 1 : 0;
      cy = 0;
      if (tk) begin
        ix = md_ph / (PMOD / 256);
        nx = md_ph + int'(phase_inc);
        cy = nx >= PMOD;
        md_ph = nx % PMOD;
        if (!md_valid || m_ready) begin
          md_data  = md_act[ix];
          md_valid = 1;
        end else if (md_drop < 255) begin
          md_drop++;
        end
      end else if (md_valid && m_ready) begin
        md_valid = 0;
      end
      sw = cy && md_pend;
      if (md_st == 0) begin
        if (c) begin
          for (int i = 0; i < 256; i++) md_act[i] = frame_in[i];
          md_st = 1;
        end
      end else if (md_st == 1) begin
        if (c)
          for (int i = 0; i < 256; i++) md_act[i] = frame_in[i];
        if (enable) md_st = 2;
      end else if (!enable) begin
        md_st = 1;
        md_ph = 0;
        if (c)
          for (int i = 0; i < 256; i++) md_act[i] = frame_in[i];
        else if (md_pend)
          md_act = md_sh;
        md_pend = 0;
      end else begin
        if (sw) md_act = md_sh;
        if (c) begin
          for (int i = 0; i < 256; i++) md_sh[i] = frame_in[i];
          md_pend = 1;
        end else if (sw) begin
          md_pend = 0;
        end
      end
      md_ack  = c;
      md_rdyq = frame_rdy;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_valid", m_valid, md_valid);
      chk("m_data", m_data, md_data);
      chk("frame_ack", frame_ack, md_ack);
      chk("playing", playing, md_st == 2);
      chk("drop_cnt", drop_cnt, md_drop);
      if (m_valid && m_ready) log_q.push_back(m_data);
      if (frame_ack) ack_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk("wait_log", log_q.size() >= n, 1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!m_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_valid", m_valid, 1);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    cyc(1);
    reload = 1'b0;
  endtask

  task automatic restart(input logic [PHASE_W-1:0] inc);
    enable = 1'b0;
    cyc(3);
    phase_inc = inc;
    log_q.delete();
    enable = 1'b1;
  endtask

  task automatic fill(input int v, input bit ramp);
    for (int i = 0; i < 256; i++)
      frame_in[i] = ramp ? 8'(i) : 8'(v);
  endtask

  initial begin : stim
    int w, b, n0, n11;
    int exp_frac[5];
    exp_frac = '{0, 2, 5, 7, 10};

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_on = 1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_playing", playing, 0);
    chk("rst_drop", drop_cnt, 0);

    // ramp capture and unit-step playback
    fill(0, 1);
    phase_inc = 16'h0100;
    m_ready   = 1'b1;
    enable    = 1'b1;
    frame_rdy = 1'b1;
    w = 0;
    b = 0;
    while (!m_valid && b < 50) begin
      @(negedge clk);
      if (playing && !m_valid) w++;
      b++;
    end
    chk("first_valid_lat", w, 4);
    wait_log(257, 1200);
    chk("ramp_0", log_q[0], 0);
    chk("ramp_1", log_q[1], 1);
    chk("ramp_2", log_q[2], 2);
    chk("ramp_255", log_q[255], 255);
    chk("ramp_wrap", log_q[256], 0);
    chk("ack_once", ack_cnt, 1);

    // fractional step 2.5
    restart(16'h0280);
    wait_log(5, 40);
    for (int k = 0; k < 5; k++)
      chk("frac_idx", log_q[k], exp_frac[k]);

    // stall for 10 ticks
    restart(16'h0100);
    m_ready = 1'b0;
    wait_valid(20);
    cyc(38);
    chk("stall_drop", drop_cnt, 9);
    chk("stall_hold", m_data, 0);
    m_ready = 1'b1;
    wait_log(2, 20);
    chk("stall_first", log_q[0], 0);
    chk("stall_next", log_q[1], 10);
    m_ready = 1'b0;
    cyc(1210);
    chk("drop_sat", drop_cnt, 255);
    m_ready = 1'b1;

    // reload mid-play swaps at the carry
    restart(16'h0100);
    wait_log(100, 500);
    fill(8'hAA, 0);
    pulse_reload();
    wait_log(258, 1200);
    chk("swap_last_old", log_q[255], 255);
    chk("swap_first_new", log_q[256], 8'hAA);
    chk("swap_second_new", log_q[257], 8'hAA);

    // two captures before the carry: newest wins
    fill(8'h11, 0);
    pulse_reload();
    cyc(4);
    fill(8'h22, 0);
    pulse_reload();
    n0 = log_q.size();
    wait_log(n0 + 256, 1200);
    n11 = 0;
    for (int k = n0; k < log_q.size(); k++)
      if (log_q[k] == 8'h11) n11++;
    chk("no_0x11", n11, 0);
    chk("last_0x22", log_q[log_q.size()-1], 8'h22);

    // disable while a sample is held
    m_ready = 1'b0;
    wait_valid(20);
    cyc(1);
    enable = 1'b0;
    cyc(2);
    chk("hold_playing", playing, 0);
    chk("hold_valid", m_valid, 1);
    chk("hold_data", m_data, 8'h22);
    m_ready = 1'b1;
    cyc(2);
    fill(0, 1);
    pulse_reload();
    cyc(2);
    restart(16'h0100);
    wait_log(3, 30);
    chk("reen_0", log_q[0], 0);
    chk("reen_1", log_q[1], 1);
    chk("reen_2", log_q[2], 2);

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0)
        phase_inc = ($urandom_range(0, 3) == 0) ? '0 :
          16'($urandom_range(256, 8191));
      if ($urandom_range(0, 249) == 0) enable = ~enable;
      if ($urandom_range(0, 199) == 0) begin
        for (int i = 0; i < 256; i++) frame_in[i] = 8'($urandom);
        reload = 1'b1;
      end else begin
        reload = 1'b0;
      end
      if ($urandom_range(0, 399) == 0) frame_rdy = ~frame_rdy;
      cyc(1);
    end

    // reset mid-stream
    reload    = 1'b0;
    frame_rdy = 1'b1;
    enable    = 1'b1;
    phase_inc = 16'h0100;
    m_ready   = 1'b0;
    cyc(20);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_ack", frame_ack, 0);
    chk("mid_rst_playing", playing, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    cyc(1);
    rst = 1'b0;
    m_ready = 1'b1;
    cyc(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
